// File: rtl/rf_dbg_access_ctrl.sv
// rf_dbg_access_ctrl: sequences debug read/write requests onto the register
// file debug port. One transaction at a time: halt the core, wait for halt and
// a quiet writeback slot, do a single-cycle access, return the response.
// Optional build macro: RF_DBG_TIMEOUT_EN bounds the halt wait and returns
// resp_err=1 when the core fails to halt within TIMEOUT_CYC cycles.
module rf_dbg_access_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              halt_req,
  input  logic              halt_ack,
  input  logic              core_wen,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [1:0] {IDLE, HALT_WAIT, ACCESS, RESP} state_t;

  state_t              state;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                acc_ok;
  logic                timeout_hit;

  // Core owns the register file unless halted and not writing back
  assign acc_ok    = halt_ack && !core_wen;
  assign req_ready = rstn && (state == IDLE);
  assign rf_addr   = lat_addr;
  assign rf_wdata  = lat_wdata;
  // Write pulse only in a qualifying ACCESS cycle; x0 is never written
  assign rf_wen    = (state == ACCESS) && acc_ok && lat_we && (lat_addr != '0);

`ifdef RF_DBG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign timeout_hit = (state == HALT_WAIT) && !acc_ok && (cnt == CNT_MAX);
  assign resp_err    = err_q;

  // Halt-wait cycle counter (saturating) and the error flag it raises
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid)
        cnt <= '0;
      else if (state == HALT_WAIT && !acc_ok && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (timeout_hit)
        err_q <= 1'b1;
      else if (state == RESP && resp_ready)
        err_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      halt_req   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we    <= req_we;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          halt_req  <= 1'b1;
          state     <= HALT_WAIT;
        end
        HALT_WAIT: begin
          if (acc_ok) begin
            state <= ACCESS;
          end else if (timeout_hit) begin
            halt_req   <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end
        end
        ACCESS: if (acc_ok) begin
          resp_rdata <= lat_we ? '0 : rf_rdata;
          halt_req   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dbg_access_ctrl.sv
// Scoreboard bench for rf_dbg_access_ctrl: stimulus pushes expected responses
// and expected register-file writes; monitors pop and compare them.
module tb_rf_dbg_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;
  logic        halt_req, halt_ack = 1'b0, core_wen = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata;
  logic        rf_load = 1'b0;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  int    n_cmp = 0, n_err = 0, wen_cnt = 0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  rf_dbg_access_ctrl #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .halt_req(halt_req), .halt_ack(halt_ack), .core_wen(core_wen),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register file model: combinational read, x0 reads 0
  assign rf_rdata = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[5] <= 32'hDEADBEEF;
    end else if (rf_wen) begin
      regs[rf_addr] <= rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response monitor: compare on handshake
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  // Write monitor: every rf_wen cycle must match a queued expected write
  always @(negedge clk) begin
    if (rstn && rf_wen) begin
      wen_cnt++;
      if (wr_q.size() == 0) begin
        chk("unexpected_rf_wen", {27'd0, rf_addr}, 32'hFFFFFFFF);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("rf_addr", {27'd0, rf_addr}, {27'd0, w.addr});
        chk("rf_wdata", rf_wdata, w.data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request for one cycle; returns at the start of HALT_WAIT
  task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    chk("req_ready_on_issue", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_resp(input logic [31:0] r, input logic e);
    resp_t x;
    x.rdata = r; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t x;
    x.addr = a; x.data = d;
    wr_q.push_back(x);
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(); n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    int w0, seen;
    // Reset
    rf_load = 1'b1;
    step(); step();
    rf_load = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    rstn = 1'b1;
    step();

    // Read x5 with halt already granted: 3-cycle latency
    halt_ack = 1'b1;
    push_resp(32'hDEADBEEF, 1'b0);
    issue(1'b0, 5'd5, 32'd0);
    @(negedge clk);
    chk("rd_c1_halt_req", {31'd0, halt_req}, 32'd1);
    chk("rd_c1_resp_valid", {31'd0, resp_valid}, 32'd0);
    step(); @(negedge clk);
    chk("rd_c2_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rd_c2_rf_addr", {27'd0, rf_addr}, 32'd5);
    step(); @(negedge clk);
    chk("rd_c3_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("rd_c3_req_ready", {31'd0, req_ready}, 32'd0);
    step(); @(negedge clk);
    chk("rd_c4_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rd_no_wen", wen_cnt, 32'd0);
    step();

    // Write x10, halt granted 4 cycles after the request
    halt_ack = 1'b0;
    w0 = wen_cnt;
    push_wr(5'd10, 32'h12345678);
    push_resp(32'd0, 1'b0);
    issue(1'b1, 5'd10, 32'h12345678);
    repeat (3) step();
    halt_ack = 1'b1;
    wait_resp(20);
    chk("wr_wen_once", wen_cnt - w0, 32'd1);
    push_resp(32'h12345678, 1'b0);
    issue(1'b0, 5'd10, 32'd0);
    wait_resp(20);

    // Collision: core writeback for 3 ACCESS cycles delays the write
    w0 = wen_cnt;
    push_wr(5'd3, 32'hA5A5A5A5);
    push_resp(32'd0, 1'b0);
    issue(1'b1, 5'd3, 32'hA5A5A5A5);
    step();
    core_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("col_rf_wen_low", {31'd0, rf_wen}, 32'd0);
      chk("col_resp_valid_low", {31'd0, resp_valid}, 32'd0);
      step();
    end
    core_wen = 1'b0;
    @(negedge clk);
    chk("col_rf_wen_pulse", {31'd0, rf_wen}, 32'd1);
    step(); @(negedge clk);
    chk("col_resp_valid", {31'd0, resp_valid}, 32'd1);
    wait_resp(10);
    chk("col_wen_once", wen_cnt - w0, 32'd1);

    // x0 write under response backpressure
    w0 = wen_cnt;
    resp_ready = 1'b0;
    push_resp(32'd0, 1'b0);
    issue(1'b1, 5'd0, 32'hFFFFFFFF);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'd0);
      chk("bp_resp_err", {31'd0, resp_err}, 32'd0);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    wait_resp(5);
    chk("x0_no_wen", wen_cnt - w0, 32'd0);
    push_resp(32'd0, 1'b0);
    issue(1'b0, 5'd0, 32'd0);
    wait_resp(20);

    // Halt never granted
    halt_ack = 1'b0;
    w0 = wen_cnt;
`ifdef RF_DBG_TIMEOUT_EN
    push_resp(32'd0, 1'b1);
    issue(1'b0, 5'd5, 32'd0);
    for (int i = 0; i < 7; i++) step();
    @(negedge clk);
    chk("to_c8_resp_valid", {31'd0, resp_valid}, 32'd0);
    step(); @(negedge clk);
    chk("to_c9_resp_valid", {31'd0, resp_valid}, 32'd1);
    wait_resp(5);
    chk("to_no_wen", wen_cnt - w0, 32'd0);
    issue(1'b1, 5'd7, 32'h55AA55AA);
    step();
`else
    issue(1'b1, 5'd7, 32'h55AA55AA);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
      step();
    end
    chk("nto_no_resp", seen, 32'd0);
`endif

    // Reset during HALT_WAIT aborts the transaction
    @(negedge clk);
    chk("pre_rst_halt_req", {31'd0, halt_req}, 32'd1);
    step();
    rstn = 1'b0;
    step(); @(negedge clk);
    chk("mid_rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_no_wen", wen_cnt - w0, 32'd0);
    rstn = 1'b1;
    step(); @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    step();

    // Recovery read
    halt_ack = 1'b1;
    push_resp(32'h12345678, 1'b0);
    issue(1'b0, 5'd10, 32'd0);
    wait_resp(20);
    chk("wr_q_drained", wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
